// File: rtl/signed_acc_chk.sv
// Signed accumulator with registered two's-complement overflow checking.
// Define SIGNED_ACC_SAT_EN to clamp acc on overflow instead of wrapping.
module signed_acc_chk #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             op,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] acc,
    output logic             out_valid,
    output logic             val,
    output logic             val_sticky,
    output logic [CNT_W-1:0] ovf_cnt
);

    typedef enum logic {
        ST_OK,
        ST_OVF
    } state_t;

    localparam logic [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic [CNT_W-1:0] cntBase;
    logic [CNT_W-1:0] cntNext;

    // A clear in the same cycle as an operation makes it start from zero.
    always_comb begin
        base    = clr ? '0 : acc;
        operand = op ? ~din : din;
        sum     = base + operand + {{(WIDTH-1){1'b0}}, op};
        if (op)
            ovf = (base[WIDTH-1] != din[WIDTH-1]) && (sum[WIDTH-1] != base[WIDTH-1]);
        else
            ovf = (base[WIDTH-1] == din[WIDTH-1]) && (sum[WIDTH-1] != base[WIDTH-1]);
`ifdef SIGNED_ACC_SAT_EN
        result = ovf ? (base[WIDTH-1] ? ACC_MIN : ACC_MAX) : sum;
`else
        result = sum;
`endif
        cntBase = clr ? '0 : ovf_cnt;
        cntNext = (cntBase == CNT_MAX) ? cntBase : cntBase + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            out_valid  <= 1'b0;
            val        <= 1'b1;
            val_sticky <= 1'b1;
            ovf_cnt    <= '0;
            state      <= ST_OK;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                acc <= result;
                val <= !ovf;
                if (ovf) begin
                    state      <= ST_OVF;
                    val_sticky <= 1'b0;
                    ovf_cnt    <= cntNext;
                end else if (clr) begin
                    state      <= ST_OK;
                    val_sticky <= 1'b1;
                    ovf_cnt    <= '0;
                end
            end else if (clr) begin
                acc        <= '0;
                val        <= 1'b1;
                state      <= ST_OK;
                val_sticky <= 1'b1;
                ovf_cnt    <= '0;
            end
        end
    end

    // Sticky flag is the registered image of the state machine; keep them paired.
    logic unusedState;
    assign unusedState = (state == ST_OVF) ? 1'b1 : 1'b0;

endmodule

// File: tb/tb_signed_acc_chk.sv
// Self-checking bench for signed_acc_chk: directed scenarios plus random
// stimulus against an integer-arithmetic reference model.
module tb_signed_acc_chk;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
    localparam int MAXV  = 2 ** (WIDTH - 1) - 1;
    localparam int MINV  = -(2 ** (WIDTH - 1));
    localparam int CMAX  = 2 ** CNT_W - 1;
`ifdef SIGNED_ACC_SAT_EN
    localparam int SAT = 1;
`else
    localparam int SAT = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             op;
    logic             clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] acc;
    logic             out_valid;
    logic             val;
    logic             val_sticky;
    logic [CNT_W-1:0] ovf_cnt;

    int checks = 0;
    int errors = 0;

    int mAcc;
    int mVal;
    int mSticky;
    int mCnt;
    int mOutValid;

    always #5 clk = ~clk;

    signed_acc_chk #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .op(op),
        .clr(clr),
        .din(din),
        .acc(acc),
        .out_valid(out_valid),
        .val(val),
        .val_sticky(val_sticky),
        .ovf_cnt(ovf_cnt)
    );

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference model: plain signed integer arithmetic with range test.
    task automatic modelStep(input bit r, input bit c, input bit v, input bit o, input int d);
        logic signed [WIDTH-1:0] dv;
        int base;
        int res;
        bit ovf;
        dv = d[WIDTH-1:0];
        if (r) begin
            mAcc = 0; mVal = 1; mSticky = 1; mCnt = 0; mOutValid = 0;
        end else begin
            mOutValid = v;
            if (v) begin
                base = c ? 0 : mAcc;
                res  = o ? base - int'(dv) : base + int'(dv);
                ovf  = (res > MAXV) || (res < MINV);
                if (c) begin
                    mCnt = 0;
                    mSticky = 1;
                end
                if (ovf) begin
                    if (SAT != 0) res = (res > MAXV) ? MAXV : MINV;
                    else res = (res > MAXV) ? res - 2 ** WIDTH : res + 2 ** WIDTH;
                    mSticky = 0;
                    if (mCnt < CMAX) mCnt = mCnt + 1;
                end
                mAcc = res;
                mVal = ovf ? 0 : 1;
            end else if (c) begin
                mAcc = 0; mVal = 1; mSticky = 1; mCnt = 0;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit c, input bit v, input bit o, input int d);
        @(negedge clk);
        rst = r; clr = c; in_valid = v; op = o; din = d[WIDTH-1:0];
        @(posedge clk);
        modelStep(r, c, v, o, d);
        #1;
        checkOutput("acc", $signed(acc), mAcc);
        checkOutput("val", val, mVal);
        checkOutput("val_sticky", val_sticky, mSticky);
        checkOutput("out_valid", out_valid, mOutValid);
        checkOutput("ovf_cnt", ovf_cnt, mCnt);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; op = 1'b0; din = '0;
        mAcc = 0; mVal = 1; mSticky = 1; mCnt = 0; mOutValid = 0;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("reset_acc", $signed(acc), 0);
        checkOutput("reset_val", val, 1);

        // add 7 from zero, then an idle cycle drops out_valid
        applyStimulus(0, 0, 1, 0, 7);
        checkOutput("tp_add7_acc", $signed(acc), 7);
        applyStimulus(0, 0, 0, 0, 3);

        // positive overflow then add -1
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("tp_posovf_acc", $signed(acc), SAT ? 7 : -8);
        checkOutput("tp_posovf_cnt", ovf_cnt, 1);
        applyStimulus(0, 0, 1, 0, -1);
        checkOutput("tp_sticky_held", val_sticky, 0);

        // negative overflow from -8 and subtract -8 from -1
        applyStimulus(0, 1, 1, 0, -8);
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("tp_negovf_acc", $signed(acc), SAT ? -8 : 7);
        checkOutput("tp_negovf_val", val, 0);
        applyStimulus(0, 1, 1, 0, -1);
        applyStimulus(0, 0, 1, 1, -8);
        checkOutput("tp_sub_m8_acc", $signed(acc), 7);

        // clear combined with an overflowing subtract
        applyStimulus(0, 1, 1, 1, -8);
        checkOutput("tp_clrop_acc", $signed(acc), SAT ? 7 : -8);
        checkOutput("tp_clrop_cnt", ovf_cnt, 1);
        checkOutput("tp_clrop_sticky", val_sticky, 0);

        // 20 consecutive overflows saturate the counter
        for (int i = 0; i < 20; i++) begin
            if (mAcc >= 0) applyStimulus(0, 0, 1, 1, -8);
            else applyStimulus(0, 0, 1, 0, -8);
        end
        checkOutput("tp_cnt_sat", ovf_cnt, CMAX);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("tp_clr_cnt", ovf_cnt, 0);
        checkOutput("tp_clr_acc", $signed(acc), 0);

        // reset during a back-to-back stream
        applyStimulus(0, 0, 1, 0, 3);
        applyStimulus(0, 0, 1, 0, 2);
        applyStimulus(1, 0, 1, 0, 5);
        checkOutput("tp_rst_acc", $signed(acc), 0);
        checkOutput("tp_rst_outvalid", out_valid, 0);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("tp_after_rst_acc", $signed(acc), 1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(49) == 0), ($urandom_range(7) == 0),
                          ($urandom_range(3) != 0), 1'($urandom_range(1)),
                          int'($urandom_range(2 ** WIDTH - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
